// File: rtl/sseg_capture_decoder.sv
// Receive side of a multiplexed 7-segment bus: waits for each digit slot to settle,
// decodes it, and commits a coherent 4-digit frame. Optional stall timeout: SSEG_CAP_TIMEOUT_EN.
module sseg_capture_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk_g,
  input  logic       rst,
  input  logic [6:0] sseg,
  input  logic [3:0] an,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] seg_err,
  output logic       frame_done,
  output logic       stalled
);

  typedef enum logic [1:0] {WAIT_SEL, SETTLE, CAPTURE, HOLD} state_t;

  if (STABLE_CYCLES < 1 || STABLE_CYCLES >= (1 << CNT_W) ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_param_chk
    $error("sseg_capture_decoder: STABLE_CYCLES/TIMEOUT_CYCLES out of range for CNT_W");
  end

  // {valid, index}: exactly one anode low
  function automatic logic [2:0] sel_decode(input logic [3:0] a);
    case (a)
      4'b1110: sel_decode = 3'b100;
      4'b1101: sel_decode = 3'b101;
      4'b1011: sel_decode = 3'b110;
      4'b0111: sel_decode = 3'b111;
      default: sel_decode = 3'b000;
    endcase
  endfunction

  // {err, value}; unknown patterns (including blank) read as 0 with err set
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40: seg_decode = 5'h00;
      7'h79: seg_decode = 5'h01;
      7'h24: seg_decode = 5'h02;
      7'h30: seg_decode = 5'h03;
      7'h19: seg_decode = 5'h04;
      7'h12: seg_decode = 5'h05;
      7'h02: seg_decode = 5'h06;
      7'h78: seg_decode = 5'h07;
      7'h00: seg_decode = 5'h08;
      7'h10: seg_decode = 5'h09;
      7'h08: seg_decode = 5'h0A;
      7'h03: seg_decode = 5'h0B;
      7'h46: seg_decode = 5'h0C;
      7'h21: seg_decode = 5'h0D;
      7'h06: seg_decode = 5'h0E;
      7'h0E: seg_decode = 5'h0F;
      default: seg_decode = 5'h10;
    endcase
  endfunction

  logic [6:0]       r_sseg_q, r_sseg_p;
  logic [3:0]       r_an_q, r_an_p;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0][3:0]  r_shadow;
  logic [3:0]       r_shadow_err;
  logic [3:0]       r_seen, w_seen_nxt;
  logic [3:0][3:0]  r_d;
  logic [3:0]       r_err;
  logic             r_frame_done;

  logic [2:0] w_sel, w_cap_sel;
  logic [4:0] w_dec;
  logic       w_changed, w_capture, w_commit, w_to_hit;

  // _q is the registered bus, _p is _q one cycle earlier for change detection
  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      r_sseg_q <= 7'h7F;
      r_an_q   <= 4'hF;
      r_sseg_p <= 7'h7F;
      r_an_p   <= 4'hF;
    end else begin
      r_sseg_q <= sseg;
      r_an_q   <= an;
      r_sseg_p <= r_sseg_q;
      r_an_p   <= r_an_q;
    end
  end

  assign w_sel     = sel_decode(r_an_q);
  assign w_changed = (r_an_q != r_an_p) || (r_sseg_q != r_sseg_p);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // In CAPTURE the _p copy still holds the value that was seen stable
  assign w_cap_sel = sel_decode(r_an_p);
  assign w_dec     = seg_decode(r_sseg_p);
  assign w_capture = (r_state == CAPTURE);
  assign w_commit  = (r_seen == 4'hF);

  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      r_state <= WAIT_SEL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WAIT_SEL: begin
        if (w_sel[2]) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = (STABLE_CYCLES <= 1) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        if (w_changed || !w_sel[2]) begin
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_SEL;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(STABLE_CYCLES)) w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (w_changed) w_state_nxt = WAIT_SEL;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_SEL;
      end
    endcase
  end

  // Commit/timeout clear first so a coincident capture leaves only its own bit
  always_comb begin
    w_seen_nxt = r_seen;
    if (w_commit || w_to_hit) w_seen_nxt = '0;
    if (w_capture) w_seen_nxt[w_cap_sel[1:0]] = 1'b1;
  end

  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_shadow_err <= '0;
      r_seen       <= '0;
    end else begin
      r_seen <= w_seen_nxt;
      for (int i = 0; i < 4; i++) begin
        if (w_capture && w_cap_sel[1:0] == 2'(i)) begin
          r_shadow[i]     <= w_dec[3:0];
          r_shadow_err[i] <= w_dec[4];
        end
      end
    end
  end

  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      r_d          <= '0;
      r_err        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_commit;
      if (w_commit) begin
        r_d   <= r_shadow;
        r_err <= r_shadow_err;
      end
    end
  end

`ifdef SSEG_CAP_TIMEOUT_EN
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_stalled;

  assign w_to_hit = !w_capture && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter parks at TIMEOUT_CYCLES so the hit fires once per stall
  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_stalled <= 1'b0;
    end else if (w_capture) begin
      r_to_cnt  <= '0;
      r_stalled <= 1'b0;
    end else begin
      if (r_to_cnt != CNT_W'(TIMEOUT_CYCLES)) r_to_cnt <= r_to_cnt + CNT_W'(1);
      if (w_to_hit) r_stalled <= 1'b1;
    end
  end

  assign stalled = r_stalled;
`else
  assign w_to_hit = 1'b0;
  assign stalled  = 1'b0;
`endif

  assign d0         = r_d[0];
  assign d1         = r_d[1];
  assign d2         = r_d[2];
  assign d3         = r_d[3];
  assign seg_err    = r_err;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sseg_capture_decoder.sv
// Directed bench for sseg_capture_decoder: settle, glitch, invalid select, reset and timeout cases.
module tb_sseg_capture_decoder;

  logic       clk_g = 1'b0;
  logic       rst;
  logic [6:0] sseg;
  logic [3:0] an;
  logic [3:0] d0, d1, d2, d3, seg_err;
  logic       frame_done, stalled;

  int n_chk = 0;
  int n_err = 0;
  int n_frames = 0;
  int base;

  sseg_capture_decoder #(
    .STABLE_CYCLES (4),
    .CNT_W         (8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_g     (clk_g),
    .rst       (rst),
    .sseg      (sseg),
    .an        (an),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .seg_err   (seg_err),
    .frame_done(frame_done),
    .stalled   (stalled)
  );

  always #5 clk_g = ~clk_g;

  always @(negedge clk_g) if (frame_done === 1'b1) n_frames++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_g);
    #1;
  endtask

  task automatic slot(input logic [3:0] a, input logic [6:0] s, input int n);
    an   = a;
    sseg = s;
    cyc(n);
  endtask

  task automatic idle(input int n);
    slot(4'hF, 7'h7F, n);
  endtask

  initial begin
    rst  = 1'b1;
    an   = 4'hF;
    sseg = 7'h7F;
    cyc(3);
    @(negedge clk_g);
    chk("rst digits", {d3, d2, d1, d0}, 16'h0000);
    chk("rst seg_err", seg_err, 4'h0);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst stalled", stalled, 1'b0);
    rst = 1'b0;
    cyc(2);

    // Slots too short to settle
    base = n_frames;
    for (int r = 0; r < 2; r++) begin
      slot(4'hE, 7'h40, 3);
      slot(4'hD, 7'h79, 3);
      slot(4'hB, 7'h24, 3);
      slot(4'h7, 7'h30, 3);
    end
    idle(6);
    @(negedge clk_g);
    chk("short frames", n_frames - base, 0);
    chk("short digits", {d3, d2, d1, d0}, 16'h0000);

    // Basic round robin
    base = n_frames;
    slot(4'hE, 7'h40, 10);
    slot(4'hD, 7'h79, 10);
    slot(4'hB, 7'h24, 10);
    slot(4'h7, 7'h30, 10);
    idle(6);
    @(negedge clk_g);
    chk("rr frames", n_frames - base, 1);
    chk("rr digits", {d3, d2, d1, d0}, 16'h3210);
    chk("rr seg_err", seg_err, 4'h0);

    // Blank glitch inside slot 0 restarts the settle count
    base = n_frames;
    slot(4'hE, 7'h40, 2);
    slot(4'hE, 7'h7F, 1);
    slot(4'hE, 7'h40, 7);
    slot(4'hD, 7'h00, 10);
    slot(4'hB, 7'h10, 10);
    slot(4'h7, 7'h08, 10);
    idle(6);
    @(negedge clk_g);
    chk("glitch frames", n_frames - base, 1);
    chk("glitch digits", {d3, d2, d1, d0}, 16'hA980);
    chk("glitch seg_err", seg_err, 4'h0);

    // Two anodes low is ignored; blank pattern in slot 2 flags an error
    base = n_frames;
    slot(4'hC, 7'h40, 20);
    slot(4'hE, 7'h79, 10);
    slot(4'hD, 7'h24, 10);
    slot(4'hB, 7'h7F, 10);
    slot(4'h7, 7'h19, 10);
    idle(6);
    @(negedge clk_g);
    chk("inv frames", n_frames - base, 1);
    chk("inv digits", {d3, d2, d1, d0}, 16'h4021);
    chk("inv seg_err", seg_err, 4'h4);

    // Reset after two captured slots discards the partial frame
    base = n_frames;
    slot(4'hB, 7'h24, 10);
    slot(4'h7, 7'h30, 10);
    an   = 4'hF;
    sseg = 7'h7F;
    rst  = 1'b1;
    cyc(2);
    @(negedge clk_g);
    chk("midrst digits", {d3, d2, d1, d0}, 16'h0000);
    chk("midrst seg_err", seg_err, 4'h0);
    rst = 1'b0;
    cyc(2);
    slot(4'hE, 7'h0E, 10);
    slot(4'hD, 7'h06, 10);
    @(negedge clk_g);
    chk("midrst partial", n_frames - base, 0);
    slot(4'hB, 7'h21, 10);
    slot(4'h7, 7'h46, 10);
    idle(6);
    @(negedge clk_g);
    chk("midrst frames", n_frames - base, 1);
    chk("midrst digits", {d3, d2, d1, d0}, 16'hCDEF);

    // Recapture of slot 0 overwrites its shadow entry
    base = n_frames;
    slot(4'hE, 7'h40, 10);
    slot(4'hE, 7'h79, 10);
    slot(4'hD, 7'h02, 10);
    slot(4'hB, 7'h78, 10);
    slot(4'h7, 7'h03, 10);
    idle(6);
    @(negedge clk_g);
    chk("recap frames", n_frames - base, 1);
    chk("recap digits", {d3, d2, d1, d0}, 16'hB761);

    // Stall timeout (50 cycles) from a clean reset
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    idle(40);
    @(negedge clk_g);
    chk("stall early", stalled, 1'b0);
    idle(20);
    @(negedge clk_g);
`ifdef SSEG_CAP_TIMEOUT_EN
    chk("stall set", stalled, 1'b1);
`else
    chk("stall set", stalled, 1'b0);
`endif
    slot(4'hE, 7'h40, 10);
    @(negedge clk_g);
    chk("stall clear", stalled, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
